// File: rtl/controller_fsm_pkg.sv
// controller_fsm_pkg: shared instruction classes, FSM states and ALU op constants
package controller_fsm_pkg;

    localparam int INSTR_BIT = 4;
    localparam int OP_BIT    = 3;

    typedef enum logic [INSTR_BIT-1:0] {
        K_NONE   = 4'd0,
        K_R      = 4'd1,
        K_I      = 4'd2,
        K_LOAD   = 4'd3,
        K_STORE  = 4'd4,
        K_BRANCH = 4'd5,
        K_LUI    = 4'd6,
        K_AUIPC  = 4'd7,
        K_JAL    = 4'd8,
        K_JALR   = 4'd9
    } kind_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [OP_BIT:0] ALU_ADD  = 4'b0000;
    localparam logic [OP_BIT:0] ALU_PASS = 4'b1111;

    function automatic logic legal(input logic [INSTR_BIT-1:0] k, input logic [6:0] f7);
        return (k >= K_R && k <= K_JALR) && (k != K_R || f7 == 7'h00 || f7 == 7'h20);
    endfunction

    // Only funct7[5] ever reaches the ALU code (SUB/SRA select)
    function automatic logic [OP_BIT:0] alu_op_of(input logic [INSTR_BIT-1:0] k,
                                                  input logic [2:0] f3, input logic f7b5);
        return (k == K_R || (k == K_I && f3[1:0] == 2'b01)) ? {f7b5, f3} :
               k == K_I   ? {1'b0, f3} :
               k == K_LUI ? ALU_PASS : ALU_ADD;
    endfunction

endpackage

// File: rtl/controller_fsm_decode.sv
// ctrl_decode: state plus captured instruction fields to datapath select signals
module ctrl_decode
    import controller_fsm_pkg::*;
(
    input  logic                 reset_n,
    input  logic [2:0]           state,
    input  logic [INSTR_BIT-1:0] kind,
    input  logic [2:0]           funct3,
    input  logic                 f7b5,
    input  logic                 branch_taken,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 pc_en,
    output logic                 ir_en,
    output logic                 sel_alu0,
    output logic                 sel_alu1,
    output logic [OP_BIT:0]      alu_op,
    output logic                 sel_ex,
    output logic                 sel_res,
    output logic                 sel_pc,
    output logic                 sel_rf_wr,
    output logic                 dmem_wr_en,
    output logic                 trap
);

    // Gating on reset_n keeps ready-driven outputs low while reset is held
    always_comb begin
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        sel_alu0   = 1'b0;
        sel_alu1   = 1'b0;
        alu_op     = ALU_ADD;
        sel_ex     = 1'b0;
        sel_res    = 1'b0;
        sel_pc     = 1'b0;
        sel_rf_wr  = 1'b0;
        dmem_wr_en = 1'b0;
        trap       = 1'b0;
        if (reset_n) begin
            case (state)
                S_FETCH: ir_en = imem_ready;
                S_EXEC: begin
                    alu_op   = alu_op_of(kind, funct3, f7b5);
                    sel_alu0 = kind == K_AUIPC || kind == K_JAL || kind == K_BRANCH;
                    sel_alu1 = kind != K_R;
                    pc_en    = kind == K_BRANCH;
                    sel_pc   = kind == K_BRANCH && branch_taken;
                end
                S_MEM: begin
                    dmem_wr_en = kind == K_STORE;
                    pc_en      = kind == K_STORE && dmem_ready;
                end
                S_WB: begin
                    sel_rf_wr = 1'b1;
                    pc_en     = 1'b1;
                    sel_res   = kind == K_LOAD;
                    sel_ex    = kind == K_JAL || kind == K_JALR;
                    sel_pc    = kind == K_JAL || kind == K_JALR;
                end
                S_TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/controller_fsm.sv
// controller_fsm: multicycle control FSM with sticky illegal-instruction trap and
// retired-instruction counter
module controller_fsm
    import controller_fsm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [INSTR_BIT-1:0] kind,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 branch_taken,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 pc_en,
    output logic                 ir_en,
    output logic                 sel_alu0,
    output logic                 sel_alu1,
    output logic [OP_BIT:0]      alu_op,
    output logic                 sel_ex,
    output logic                 sel_res,
    output logic                 sel_pc,
    output logic                 sel_rf_wr,
    output logic                 dmem_wr_en,
    output logic                 trap,
    output logic [WIDTH-1:0]     instret
);

    state_t               state, state_nx;
    logic [INSTR_BIT-1:0] kind_q;
    logic [2:0]           funct3_q;
    logic                 f7b5_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_FETCH;
            kind_q   <= '0;
            funct3_q <= '0;
            f7b5_q   <= 1'b0;
            instret  <= '0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) begin
                kind_q   <= kind;
                funct3_q <= funct3;
                f7b5_q   <= funct7[5];
            end
            if (pc_en)
                instret <= instret + WIDTH'(1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  state_nx = imem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_nx = legal(kind, funct7) ? S_EXEC : S_TRAP;
            S_EXEC:   state_nx = (kind_q == K_LOAD || kind_q == K_STORE) ? S_MEM :
                                 kind_q == K_BRANCH ? S_FETCH : S_WB;
            S_MEM:    state_nx = !dmem_ready ? S_MEM : kind_q == K_LOAD ? S_WB : S_FETCH;
            S_WB:     state_nx = S_FETCH;
            S_TRAP:   state_nx = S_TRAP;
            default:  state_nx = S_FETCH;
        endcase
    end

    ctrl_decode u_decode (
        .reset_n      (reset_n),
        .state        (state),
        .kind         (kind_q),
        .funct3       (funct3_q),
        .f7b5         (f7b5_q),
        .branch_taken (branch_taken),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .pc_en        (pc_en),
        .ir_en        (ir_en),
        .sel_alu0     (sel_alu0),
        .sel_alu1     (sel_alu1),
        .alu_op       (alu_op),
        .sel_ex       (sel_ex),
        .sel_res      (sel_res),
        .sel_pc       (sel_pc),
        .sel_rf_wr    (sel_rf_wr),
        .dmem_wr_en   (dmem_wr_en),
        .trap         (trap)
    );

endmodule

// File: tb/tb_controller_fsm.sv
// tb_controller_fsm: randomized instruction stream checked cycle by cycle against a
// schedule computed from instruction class and stall counts
module tb_controller_fsm;
    import controller_fsm_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  kind = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic        branch_taken = 1'b0;
    logic        imem_ready = 1'b1;
    logic        dmem_ready = 1'b1;
    logic        pc_en, ir_en, sel_alu0, sel_alu1, sel_ex, sel_res, sel_pc, sel_rf_wr, dmem_wr_en, trap;
    logic [3:0]  alu_op;
    logic [31:0] instret;
    logic        n_pc_en, n_ir_en, n_sel_alu0, n_sel_alu1, n_sel_ex, n_sel_res, n_sel_pc;
    logic        n_sel_rf_wr, n_dmem_wr_en, n_trap;
    logic [3:0]  n_alu_op;
    logic [3:0]  n_instret;
    logic [13:0] outs;
    int          checks = 0;
    int          failures = 0;
    int unsigned retired = 0;

    always #5 clk = ~clk;

    assign outs = {pc_en, ir_en, sel_alu0, sel_alu1, alu_op, sel_ex, sel_res, sel_pc,
                   sel_rf_wr, dmem_wr_en, trap};

    controller_fsm dut (
        .clk(clk), .reset_n(reset_n), .kind(kind), .funct3(funct3), .funct7(funct7),
        .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ir_en(ir_en), .sel_alu0(sel_alu0), .sel_alu1(sel_alu1),
        .alu_op(alu_op), .sel_ex(sel_ex), .sel_res(sel_res), .sel_pc(sel_pc),
        .sel_rf_wr(sel_rf_wr), .dmem_wr_en(dmem_wr_en), .trap(trap), .instret(instret)
    );

    controller_fsm #(.WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .kind(kind), .funct3(funct3), .funct7(funct7),
        .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pc_en(n_pc_en), .ir_en(n_ir_en), .sel_alu0(n_sel_alu0), .sel_alu1(n_sel_alu1),
        .alu_op(n_alu_op), .sel_ex(n_sel_ex), .sel_res(n_sel_res), .sel_pc(n_sel_pc),
        .sel_rf_wr(n_sel_rf_wr), .dmem_wr_en(n_dmem_wr_en), .trap(n_trap), .instret(n_instret)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_legal(input logic [3:0] k, input logic [6:0] f7);
        return k >= 4'd1 && k <= 4'd9 && (k != 4'd1 || f7 == 7'h00 || f7 == 7'h20);
    endfunction

    function automatic logic [3:0] exp_op(input logic [3:0] k, input logic [2:0] f3, input logic [6:0] f7);
        if (k == K_R) return {f7[5], f3};
        if (k == K_I) return (f3 == 3'd1 || f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3};
        if (k == K_LUI) return 4'hF;
        return 4'h0;
    endfunction

    function automatic int length(input logic [3:0] k, input logic [6:0] f7, input int a, input int b);
        if (!is_legal(k, f7)) return a + 22;
        if (k == K_BRANCH) return a + 3;
        if (k == K_STORE) return a + 4 + b;
        if (k == K_LOAD) return a + 5 + b;
        return a + 4;
    endfunction

    // Cycles: a fetch stalls, fetch, decode, exec, then b+1 memory cycles for
    // loads/stores, then write-back for everything except stores and branches
    function automatic logic [13:0] exp_outs(input int t, input int a, input int b, input logic [3:0] k,
                                             input logic [2:0] f3, input logic [6:0] f7, input logic bt);
        logic [13:0] e = '0;
        logic ls = k == K_LOAD || k == K_STORE;
        logic jmp = k == K_JAL || k == K_JALR;
        if (t == a) e[12] = 1'b1;
        else if (!is_legal(k, f7)) e[0] = t >= a + 2;
        else if (t == a + 2) begin
            e[11] = k == K_AUIPC || k == K_JAL || k == K_BRANCH;
            e[10] = k != K_R;
            e[9:6] = exp_op(k, f3, f7);
            e[13] = k == K_BRANCH;
            e[3] = k == K_BRANCH && bt;
        end else if (ls && t >= a + 3 && t <= a + 3 + b) begin
            e[1] = k == K_STORE;
            e[13] = k == K_STORE && t == a + 3 + b;
        end else if (k != K_STORE && k != K_BRANCH && t == a + 3 + (ls ? b + 1 : 0)) begin
            e[13] = 1'b1;
            e[2] = 1'b1;
            e[4] = k == K_LOAD;
            e[5] = jmp;
            e[3] = jmp;
        end
        return e;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_outs", 32'(outs), 32'h0);
        check("rst_instret", instret, 32'h0);
        check("rst_instret4", 32'(n_instret), 32'h0);
        retired = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic run_instr(input logic [3:0] k, input logic [2:0] f3, input logic [6:0] f7,
                             input logic bt, input int a, input int b, input int rst_at);
        int len = length(k, f7, a, b);
        logic ls = k == K_LOAD || k == K_STORE;
        for (int t = 0; t < len; t++) begin
            kind = t <= a + 1 ? k : 4'($urandom);
            funct3 = t <= a + 1 ? f3 : 3'($urandom);
            funct7 = t <= a + 1 ? f7 : 7'($urandom);
            branch_taken = bt;
            imem_ready = t < a ? 1'b0 : t == a ? 1'b1 : 1'($urandom);
            dmem_ready = (ls && t >= a + 3 && t <= a + 3 + b) ? (t == a + 3 + b) : 1'($urandom);
            if (t == rst_at) begin
                #2 check("wr_pre", 32'(dmem_wr_en), 32'h1);
                do_reset();
                return;
            end
            @(negedge clk);
            check($sformatf("out_k%0d_t%0d", k, t), 32'(outs), 32'(exp_outs(t, a, b, k, f3, f7, bt)));
            @(posedge clk);
            #1;
        end
        if (is_legal(k, f7)) retired++;
        check("instret", instret, retired);
        check("instret4", 32'(n_instret), retired % 16);
        if (!is_legal(k, f7)) do_reset();
    endtask

    initial begin
        logic [3:0] k;
        logic [6:0] f7;
        #2;
        check("rst_outs0", 32'(outs), 32'h0);
        check("rst_instret0", instret, 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        run_instr(K_R, 3'd0, 7'h00, 1'b0, 0, 0, -1);
        run_instr(K_R, 3'd0, 7'h20, 1'b0, 2, 0, -1);
        run_instr(K_LOAD, 3'd2, 7'h00, 1'b0, 0, 3, -1);
        run_instr(K_STORE, 3'd2, 7'h00, 1'b0, 0, 3, 4);
        run_instr(K_BRANCH, 3'd0, 7'h00, 1'b1, 0, 0, -1);
        run_instr(K_BRANCH, 3'd1, 7'h00, 1'b0, 0, 0, -1);
        run_instr(K_LUI, 3'd0, 7'h00, 1'b0, 0, 0, -1);
        run_instr(K_I, 3'd5, 7'h20, 1'b0, 0, 0, -1);
        run_instr(K_R, 3'd0, 7'h01, 1'b0, 0, 0, -1);
        for (int i = 0; i < 17; i++)
            run_instr(K_I, 3'($urandom), 7'($urandom), 1'($urandom), 0, 0, -1);
        for (int i = 0; i < 300; i++) begin
            k = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 16) % 16) : 4'($urandom_range(1, 9));
            f7 = $urandom_range(0, 7) == 0 ? 7'($urandom) : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
            run_instr(k, 3'($urandom), f7, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controller_fsm.md
CONTROLLER_FSM -- requirements
Module: controller_fsm

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port kind, input, `INSTR_BIT bits: decoded instruction class from the datapath.
REQ-005 SHALL have ports funct3 (input, 3 bits) and funct7 (input, 7 bits): instruction function fields.
REQ-006 SHALL have port branch_taken, input, 1 bit: datapath comparator result, valid in EXEC.
REQ-007 SHALL have ports imem_ready and dmem_ready, input, 1 bit each: memory access complete this cycle.
REQ-008 SHALL have outputs pc_en and ir_en, 1 bit each: PC update enable and instruction-register load enable.
REQ-009 SHALL have outputs sel_alu0 (0=rs1, 1=PC) and sel_alu1 (0=rs2, 1=imm), 1 bit each.
REQ-010 SHALL have output alu_op, `OP_BIT+1 bits (`OP_BIT = 3): ALU operation code.
REQ-011 SHALL have outputs sel_ex (0=ALU result, 1=PC+4), sel_res (0=ex result, 1=dmem rdata) and sel_pc (0=PC+4, 1=ALU result register), 1 bit each.
REQ-012 SHALL have outputs sel_rf_wr (register-file write enable) and dmem_wr_en, 1 bit each.
REQ-013 SHALL have outputs trap (1 bit, sticky illegal-instruction flag) and instret (WIDTH bits, retired-instruction count).

Function
REQ-014 SHALL implement a Moore FSM with states FETCH, DECODE, EXEC, MEM, WB and TRAP; outputs depend only on the state and the kind/funct registers captured in DECODE.
REQ-015 FETCH SHALL hold until imem_ready=1; in that cycle it SHALL pulse ir_en and move to DECODE.
REQ-016 DECODE SHALL last 1 cycle, capture kind/funct3/funct7, and go to TRAP if kind is unknown or R-type funct7 is not 0x00 or 0x20; otherwise it SHALL go to EXEC.
REQ-017 EXEC transitions: R/I/LUI/AUIPC/JAL/JALR to WB; LOAD/STORE to MEM; BRANCH to FETCH with pc_en=1 and sel_pc=branch_taken.
REQ-018 alu_op encoding: {funct7[5],funct3} for R-type; {funct7[5],funct3} for I-type shifts (funct3=x01); {0,funct3} for other I-type; 4'b0000 (ADD) for LOAD/STORE/AUIPC/JAL/JALR/BRANCH target; 4'b1111 (pass operand 1) for LUI.
REQ-019 EXEC operand selects: sel_alu0=1 for AUIPC/JAL/BRANCH, else 0; sel_alu1=0 for R-type only, else 1.
REQ-020 MEM for STORE SHALL hold dmem_wr_en=1 until dmem_ready=1, then assert pc_en with sel_pc=0 and go to FETCH.
REQ-021 MEM for LOAD SHALL wait for dmem_ready=1, then go to WB.
REQ-022 WB SHALL assert sel_rf_wr=1 and pc_en=1 for exactly 1 cycle, then go to FETCH. In WB: sel_res=1 for LOAD; sel_ex=1 and sel_pc=1 for JAL/JALR; otherwise all three are 0.
REQ-023 Latency with ready inputs held at 1: BRANCH 3 cycles, R/I/LUI/AUIPC/JAL/JALR/STORE 4 cycles, LOAD 5 cycles.
REQ-024 instret SHALL increment by 1 on every cycle with pc_en=1, wrapping from 2^WIDTH-1 to 0.
REQ-025 TRAP SHALL be absorbing: trap=1, and pc_en, ir_en, sel_rf_wr and dmem_wr_en held at 0 until reset.
REQ-026 In every state, any output not specified above SHALL be 0.

Reset
REQ-027 reset_n=0 SHALL immediately force state FETCH, all outputs 0, instret=0, trap=0 and the captured fields to 0, including mid-access (dmem_wr_en drops without waiting for a clock edge).
REQ-028 After release, the first ir_en SHALL occur on the first edge where imem_ready=1.

Structure
REQ-029 The kind enumeration, state enumeration and alu_op constants (ADD=4'b0000, PASS=4'b1111) SHALL reside in the shared def.h / package.
REQ-030 Output decode SHALL be a combinational sub-module ctrl_decode (state + captured fields to select signals); the state register and instret counter remain in controller_fsm.

Verification
REQ-031 ADD (kind=R, funct3=0, funct7=0x00), ready=1 -> ir_en in cycle 1, alu_op=0000 in EXEC, sel_rf_wr=1 and pc_en=1 in cycle 4, instret 0 -> 1.
REQ-032 LOAD with dmem_ready low for 3 cycles -> MEM lasts 4 cycles, WB has sel_res=1, total 8 cycles.
REQ-033 STORE with dmem_ready=0, reset_n pulsed low mid-MEM -> dmem_wr_en falls asynchronously, state returns to FETCH, instret=0.
REQ-034 BRANCH with branch_taken=1, then with branch_taken=0 -> sel_pc=1 then 0 with pc_en in cycle 3, sel_rf_wr never asserted.
REQ-035 R-type funct7=0x01 -> trap=1 from cycle 3 onward, no pc_en for 20 cycles, cleared only by reset.
REQ-036 instret preloaded via forced WIDTH=4 build to 15, one retire -> instret=0.
